// File: rtl/mux2to1_arbiter.sv
// Two-requester packet arbiter that drives a shared 2:1 mux. Grants last until
// end of packet, MAX_BURST beats, or the owner withdraws; the priority flips after each grant.
module mux2to1_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             gnt_b,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t          state, state_nxt;
  logic            prio, prio_nxt;
  logic [BW-1:0]   bcnt, bcnt_nxt;

  // Requesters packed so the granted side is one index away.
  logic [1:0]            req, last;
  logic [1:0][WIDTH-1:0] data;
  logic                  side, granted, accept, release_g;

  assign req  = {req_b, req_a};
  assign last = {last_b, last_a};
  assign data = {data_b, data_a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (req_a && req_b)  state_nxt = prio ? GRANT_B : GRANT_A;
        else if (req_a)      state_nxt = GRANT_A;
        else if (req_b)      state_nxt = GRANT_B;
      end
      GRANT_A, GRANT_B: begin
        if (release_g) begin
          // Hand straight over to the other side when it is waiting.
          if (req[~side]) state_nxt = side ? GRANT_A : GRANT_B;
          else            state_nxt = IDLE;
          prio_nxt = ~side;
          bcnt_nxt = '0;
        end else if (accept) begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    granted   = (state == GRANT_A) || (state == GRANT_B);
    side      = (state == GRANT_B);
    gnt_a     = (state == GRANT_A);
    gnt_b     = (state == GRANT_B);
    out_sel   = side;
    out_valid = granted & req[side];
    out_data  = granted ? data[side] : '0;
    accept    = out_valid & out_ready;
    release_g = granted & (~req[side] | (accept & (last[side] | (bcnt == BCNT_MAX))));
  end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Directed bench for mux2to1_arbiter: reset, single grant, alternation,
// burst limit, backpressure, asynchronous mid-burst reset and withdrawal.
module tb_mux2to1_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, last_a, gnt_a, req_b, last_b, gnt_b;
  logic [7:0] data_a, data_b, out_data;
  logic       out_ready, out_valid, out_sel;

  int n_chk  = 0;
  int n_fail = 0;

  mux2to1_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .last_a(last_a), .gnt_a(gnt_a),
    .req_b(req_b), .data_b(data_b), .last_b(last_b), .gnt_b(gnt_b),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; req_a = 0; req_b = 0; last_a = 0; last_b = 0;
    data_a = 8'h00; data_b = 8'h00; out_ready = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_sel",   out_sel, 0);

    // Single requester, one-beat packet
    cyc();
    rst = 1'b0;
    req_a = 1; data_a = 8'hA5; last_a = 1; out_ready = 1;
    cyc();
    chk("single_gnt_a", gnt_a, 1);
    chk("single_data",  out_data, 8'hA5);
    chk("single_valid", out_valid, 1);
    chk("single_sel",   out_sel, 0);
    req_a = 0;
    cyc();
    chk("single_idle_gnt_a", gnt_a, 0);
    chk("single_idle_valid", out_valid, 0);

    // Fresh reset, then both requesting with one-beat packets: A,B,A,B
    rst = 1'b1; #2 rst = 1'b0;
    req_a = 1; req_b = 1; last_a = 1; last_b = 1; data_a = 8'h11; data_b = 8'h22;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("alt_sel",   out_sel, i % 2);
      chk("alt_gnt_a", gnt_a, (i % 2) == 0);
      chk("alt_gnt_b", gnt_b, (i % 2) == 1);
      chk("alt_data",  out_data, (i % 2) ? 8'h22 : 8'h11);
      chk("alt_valid", out_valid, 1);
    end
    req_a = 0; req_b = 0;
    cyc();
    chk("alt_idle_gnt_b", gnt_b, 0);
    chk("alt_idle_valid", out_valid, 0);

    // Burst limit: A gets exactly 4 beats then B takes over
    req_a = 1; req_b = 1; last_a = 0; last_b = 0; data_a = 8'h33; data_b = 8'h44;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("burst_gnt_a", gnt_a, 1);
      chk("burst_data",  out_data, 8'h33);
      chk("burst_gnt_b", gnt_b, 0);
    end
    cyc();
    chk("burst_then_b", gnt_b, 1);
    chk("burst_then_a", gnt_a, 0);

    // Backpressure in GRANT_B after one accepted beat: 5 stalled cycles
    cyc();
    chk("bp_pre_gnt_b", gnt_b, 1);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_gnt_b", gnt_b, 1);
      chk("bp_data",  out_data, 8'h44);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1;
    cyc();
    chk("bp_beat3_gnt_b", gnt_b, 1);
    cyc();
    chk("bp_beat4_gnt_b", gnt_b, 1);
    cyc();
    chk("bp_release_a", gnt_a, 1);
    chk("bp_release_b", gnt_b, 0);

    // Move to GRANT_B via A withdrawing, then reset asynchronously mid-burst
    req_a = 0;
    cyc();
    chk("mr_gnt_b", gnt_b, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_drop_gnt_b", gnt_b, 0);
    chk("mr_drop_valid", out_valid, 0);
    chk("mr_drop_sel",   out_sel, 0);
    chk("mr_drop_data",  out_data, 0);
    #1 rst = 1'b0;
    req_a = 1; req_b = 1;
    cyc();
    chk("mr_prio_a", gnt_a, 1);
    chk("mr_prio_b", gnt_b, 0);

    // Requester A withdraws with B idle
    req_a = 0; req_b = 0;
    #1;
    chk("wd_valid", out_valid, 0);
    chk("wd_gnt_a_hold", gnt_a, 1);
    cyc();
    chk("wd_idle_gnt_a", gnt_a, 0);
    chk("wd_idle_gnt_b", gnt_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
